// File: rtl/mc_controller_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// MC_CONTROLLER_JUMP_EN adds the Jump strobe.
interface mc_controller_if;
  logic [5:0] OpCode;
  logic       mem_ack;
  logic       mem_req;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegDst;
  logic       AluSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Branch;
  logic       Ne;
  logic [1:0] ALUOp;
`ifdef MC_CONTROLLER_JUMP_EN
  logic       Jump;
`endif

  modport master (
    input  OpCode, mem_ack,
    output mem_req, IRWrite, PCWrite, RegDst, AluSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, Branch, Ne, ALUOp
`ifdef MC_CONTROLLER_JUMP_EN
    , output Jump
`endif
  );

  modport slave (
    output OpCode, mem_ack,
    input  mem_req, IRWrite, PCWrite, RegDst, AluSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, Branch, Ne, ALUOp
`ifdef MC_CONTROLLER_JUMP_EN
    , input Jump
`endif
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with wait-stated memory and timeout fault.
// Optional feature: MC_CONTROLLER_JUMP_EN makes opcode 000010 a legal jump.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus,
  output logic [2:0]      state,
  output logic            halted,
  output logic            fault,
  output logic            illegal
);

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
`ifdef MC_CONTROLLER_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IDLE   = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             illegal_q, illegal_d;
  logic             mem_req_c;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE: op_legal = 1'b1;
`ifdef MC_CONTROLLER_JUMP_EN
      OP_J:                                        op_legal = 1'b1;
`endif
      default:                                     op_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state, opcode latch, timeout counter and sticky status.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    fault_d   = fault_q;
    illegal_d = ILLEGAL_HALT ? illegal_q : 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = bus.OpCode;
        if (op_legal(bus.OpCode)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_LW, OP_SW:   state_d = S_MEM;
          OP_R, OP_ADDI:  state_d = S_WB;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (bus.mem_ack) state_d = (opcode_q == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    // Timeout overrides any transition; the pending access is dropped.
    if (mem_req_c && !bus.mem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1))) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end
    cnt_d = (mem_req_c && !bus.mem_ack && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  // Moore decode from state and latched opcode; only fetch strobes qualify on mem_ack.
  always_comb begin
    mem_req_c    = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.AluSrc   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Branch   = 1'b0;
    bus.Ne       = 1'b0;
    bus.ALUOp    = 2'b00;
`ifdef MC_CONTROLLER_JUMP_EN
    bus.Jump     = 1'b0;
`endif
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (opcode_q)
        OP_R:          begin bus.RegDst = 1'b1; bus.ALUOp = 2'b10; end
        OP_LW:         begin bus.AluSrc = 1'b1; bus.MemtoReg = 1'b1; end
        OP_SW,OP_ADDI: bus.AluSrc = 1'b1;
        OP_BEQ,OP_BNE: bus.ALUOp = 2'b01;
        default:       ;
      endcase
    end
    case (state_q)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        bus.IRWrite = bus.mem_ack;
        bus.PCWrite = bus.mem_ack;
      end
      S_EXEC: begin
        bus.Branch = (opcode_q == OP_BEQ) || (opcode_q == OP_BNE);
        bus.Ne     = (opcode_q == OP_BNE);
`ifdef MC_CONTROLLER_JUMP_EN
        bus.Jump   = (opcode_q == OP_J);
`endif
      end
      S_MEM: begin
        mem_req_c    = 1'b1;
        bus.MemRead  = (opcode_q == OP_LW);
        bus.MemWrite = (opcode_q == OP_SW);
      end
      S_WB:    bus.RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req = mem_req_c;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = fault_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (default build plus an ILLEGAL_HALT=0 instance).
module tb_mc_controller;

  // ctl = {mem_req,IRWrite,PCWrite,RegDst,AluSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Ne,ALUOp}
  localparam logic [12:0] Z     = 13'b0_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [12:0] F1    = 13'b1_1_1_0_0_0_0_0_0_0_0_00;
  localparam logic [12:0] F0    = 13'b1_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [12:0] R_EX  = 13'b0_0_0_1_0_0_0_0_0_0_0_10;
  localparam logic [12:0] R_WB  = 13'b0_0_0_1_0_0_1_0_0_0_0_10;
  localparam logic [12:0] LW_EX = 13'b0_0_0_0_1_1_0_0_0_0_0_00;
  localparam logic [12:0] LW_MM = 13'b1_0_0_0_1_1_0_1_0_0_0_00;
  localparam logic [12:0] LW_WB = 13'b0_0_0_0_1_1_1_0_0_0_0_00;
  localparam logic [12:0] SW_EX = 13'b0_0_0_0_1_0_0_0_0_0_0_00;
  localparam logic [12:0] SW_MM = 13'b1_0_0_0_1_0_0_0_1_0_0_00;
  localparam logic [12:0] AI_WB = 13'b0_0_0_0_1_0_1_0_0_0_0_00;
  localparam logic [12:0] BNE_E = 13'b0_0_0_0_0_0_0_0_0_1_1_01;
  localparam logic [12:0] BEQ_E = 13'b0_0_0_0_0_0_0_0_0_1_0_01;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus_a ();
  mc_controller_if bus_b ();

  logic [2:0] state_a, state_b;
  logic halted_a, fault_a, illegal_a, halted_b, fault_b, illegal_b;
  logic [12:0] ctl_a, ctl_b;

  mc_controller dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .state(state_a), .halted(halted_a), .fault(fault_a), .illegal(illegal_a)
  );

  mc_controller #(.MEM_TIMEOUT(15), .ILLEGAL_HALT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .state(state_b), .halted(halted_b), .fault(fault_b), .illegal(illegal_b)
  );

  assign ctl_a = {bus_a.mem_req, bus_a.IRWrite, bus_a.PCWrite, bus_a.RegDst, bus_a.AluSrc,
                  bus_a.MemtoReg, bus_a.RegWrite, bus_a.MemRead, bus_a.MemWrite,
                  bus_a.Branch, bus_a.Ne, bus_a.ALUOp};
  assign ctl_b = {bus_b.mem_req, bus_b.IRWrite, bus_b.PCWrite, bus_b.RegDst, bus_b.AluSrc,
                  bus_b.MemtoReg, bus_b.RegWrite, bus_b.MemRead, bus_b.MemWrite,
                  bus_b.Branch, bus_b.Ne, bus_b.ALUOp};

  int n_checks = 0;
  int n_pass   = 0;

  // Leaves both DUTs in IDLE, just after reset release, away from a clock edge.
  task automatic reset_dut();
    reset = 1'b0;
    bus_a.mem_ack = 1'b1; bus_a.OpCode = 6'b000000;
    bus_b.mem_ack = 1'b1; bus_b.OpCode = 6'b000000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.mem_ack = 1'b1; bus_a.OpCode = 6'b000000;
    bus_b.mem_ack = 1'b1; bus_b.OpCode = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({state_a, ctl_a, halted_a, fault_a, illegal_a} !== {3'd5, Z, 3'b000})
      $display("FAIL reset_a: got %h expected %h", {state_a, ctl_a, halted_a, fault_a, illegal_a}, {3'd5, Z, 3'b000});
    else n_pass++;
    n_checks++;
    if ({state_b, ctl_b, halted_b, fault_b, illegal_b} !== {3'd5, Z, 3'b000})
      $display("FAIL reset_b: got %h expected %h", {state_b, ctl_b, halted_b, fault_b, illegal_b}, {3'd5, Z, 3'b000});
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({state_a, ctl_a} !== {3'd5, Z})
      $display("FAIL reset_cycle1: got %h expected %h", {state_a, ctl_a}, {3'd5, Z});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({state_a, ctl_a} !== {3'd0, F1})
      $display("FAIL reset_cycle2_fetch: got %h expected %h", {state_a, ctl_a}, {3'd0, F1});
    else n_pass++;
  endtask

  task automatic test_rtype();
    logic [15:0] exp [5] = '{{3'd0, F1}, {3'd1, Z}, {3'd2, R_EX}, {3'd4, R_WB}, {3'd0, F1}};
    reset_dut();
    bus_a.OpCode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      n_checks++;
      if ({state_a, ctl_a} !== exp[i])
        $display("FAIL rtype_cyc%0d: got %h expected %h", i, {state_a, ctl_a}, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lw_wait();
    logic [15:0] exp [8] = '{{3'd0, F1}, {3'd1, Z}, {3'd2, LW_EX}, {3'd3, LW_MM},
                             {3'd3, LW_MM}, {3'd3, LW_MM}, {3'd4, LW_WB}, {3'd0, F0}};
    logic [7:0] ack = 8'b0010_0111;  // bit i = mem_ack during cycle i
    reset_dut();
    bus_a.OpCode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus_a.mem_ack = ack[i];
      #1;
      n_checks++;
      if ({state_a, ctl_a} !== exp[i])
        $display("FAIL lw_cyc%0d: got %h expected %h", i, {state_a, ctl_a}, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_bne();
    logic [15:0] exp [4] = '{{3'd0, F1}, {3'd1, Z}, {3'd2, BNE_E}, {3'd0, F0}};
    reset_dut();
    bus_a.OpCode = 6'b000101;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus_a.mem_ack = (i != 3);
      #1;
      n_checks++;
      if ({state_a, ctl_a} !== exp[i])
        $display("FAIL bne_cyc%0d: got %h expected %h", i, {state_a, ctl_a}, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [8] = '{{3'd0, F1}, {3'd1, Z}, {3'd2, SW_EX}, {3'd4, AI_WB},
                             {3'd0, F1}, {3'd1, Z}, {3'd2, BEQ_E}, {3'd0, F1}};
    logic [5:0] op [8] = '{6'b001000, 6'b001000, 6'b001000, 6'b000100,
                           6'b000100, 6'b000100, 6'b000100, 6'b000100};
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus_a.OpCode = op[i];
      #1;
      n_checks++;
      if ({state_a, ctl_a} !== exp[i])
        $display("FAIL b2b_cyc%0d: got %h expected %h", i, {state_a, ctl_a}, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [15:0] exp;
    reset_dut();
    bus_a.OpCode = 6'b101011;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      bus_a.mem_ack = (i == 0);
      #1;
      if (i == 0)       exp = {3'd0, F1};
      else if (i == 1)  exp = {3'd1, Z};
      else if (i == 2)  exp = {3'd2, SW_EX};
      else if (i < 18)  exp = {3'd3, SW_MM};
      else              exp = {3'd7, Z};
      n_checks++;
      if ({state_a, ctl_a} !== exp)
        $display("FAIL timeout_cyc%0d: got %h expected %h", i, {state_a, ctl_a}, exp);
      else n_pass++;
    end
    n_checks++;
    if ({halted_a, fault_a, illegal_a} !== 3'b110)
      $display("FAIL timeout_status: got %b expected %b", {halted_a, fault_a, illegal_a}, 3'b110);
    else n_pass++;
    bus_a.mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({state_a, ctl_a, halted_a} !== {3'd7, Z, 1'b1})
      $display("FAIL halt_sticky: got %h expected %h", {state_a, ctl_a, halted_a}, {3'd7, Z, 1'b1});
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({state_a, fault_a, halted_a} !== {3'd5, 2'b00})
      $display("FAIL reset_clears_fault: got %h expected %h", {state_a, fault_a, halted_a}, {3'd5, 2'b00});
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_illegal_halt();
    logic [15:0] exp [4] = '{{3'd0, F1}, {3'd1, Z}, {3'd7, Z}, {3'd7, Z}};
    reset_dut();
    bus_a.OpCode = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      n_checks++;
      if ({state_a, ctl_a} !== exp[i])
        $display("FAIL illegal_halt_cyc%0d: got %h expected %h", i, {state_a, ctl_a}, exp[i]);
      else n_pass++;
    end
    n_checks++;
    if ({halted_a, fault_a, illegal_a} !== 3'b101)
      $display("FAIL illegal_halt_status: got %b expected %b", {halted_a, fault_a, illegal_a}, 3'b101);
    else n_pass++;
`ifndef MC_CONTROLLER_JUMP_EN
    reset_dut();
    bus_a.OpCode = 6'b000010;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({state_a, illegal_a} !== {3'd7, 1'b1})
      $display("FAIL jump_illegal: got %h expected %h", {state_a, illegal_a}, {3'd7, 1'b1});
    else n_pass++;
`endif
  endtask

  task automatic test_illegal_nop();
    logic [17:0] exp [5] = '{{3'd0, F1, 2'b00}, {3'd1, Z, 2'b00}, {3'd0, F0, 2'b10},
                             {3'd0, F0, 2'b00}, {3'd0, F0, 2'b00}};
    reset_dut();
    bus_b.OpCode = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus_b.mem_ack = (i < 2);
      #1;
      n_checks++;
      if ({state_b, ctl_b, illegal_b, halted_b} !== exp[i])
        $display("FAIL illegal_nop_cyc%0d: got %h expected %h", i, {state_b, ctl_b, illegal_b, halted_b}, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    reset_dut();
    bus_a.OpCode = 6'b000000;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({state_a, ctl_a} !== {3'd4, R_WB})
      $display("FAIL abort_pre: got %h expected %h", {state_a, ctl_a}, {3'd4, R_WB});
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({state_a, ctl_a} !== {3'd5, Z})
      $display("FAIL abort_async: got %h expected %h", {state_a, ctl_a}, {3'd5, Z});
    else n_pass++;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_bne();
    test_back_to_back();
    test_timeout();
    test_illegal_halt();
    test_illegal_nop();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
